// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, start/data/parity/stop FSM on a 16x-style oversample tick.
// Result registers update on the stop-sample edge, so donerx is visible the cycle after; no backpressure.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 baud_rtick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 donerx,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  assign rx_s = sync2_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      rx_data_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      rx_data_q <= rx_data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Counting from the falling edge puts every later sample near mid-bit.
        if (baud_rtick) begin
          if (cnt_q == CNT_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (baud_rtick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d[idx_q] = rx_s;
            cnt_d          = '0;
            idx_d          = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_rtick) begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is caught.
        if (baud_rtick) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            rx_data_d = shift_q;
            perr_d    = PAR_ON & (par_q ^ (^shift_q));
            ferr_d    = ~rx_s;
            done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign donerx     = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one parity-enabled and one parity-less instance, directed plus random frames,
// checked against a frame-level expectation queue and a per-cycle held-output model.
module tb_uart_receiver;

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       baud_rtick = 1'b1;
  logic       rx_p = 1'b1, rx_n = 1'b1;
  logic [7:0] rx_data_p, rx_data_n;
  logic       done_p, done_n, perr_p, perr_n, ferr_p, ferr_n, busy_p, busy_n;

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1), .OVERSAMPLE(16)) dut_p (
    .clk1(clk1), .rst(rst), .baud_rtick(baud_rtick), .rx(rx_p),
    .rx_data(rx_data_p), .donerx(done_p), .parity_err(perr_p), .frame_err(ferr_p), .busy(busy_p)
  );

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(0), .OVERSAMPLE(16)) dut_n (
    .clk1(clk1), .rst(rst), .baud_rtick(baud_rtick), .rx(rx_n),
    .rx_data(rx_data_n), .donerx(done_n), .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q_p[$];
  exp_t q_n[$];
  int   done_n_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Held-output model: outputs change only on a completed frame or a reset.
  bit         rst_seen = 1'b0;
  logic [7:0] hp = 8'h00, hn = 8'h00;
  logic       hpe = 1'b0, hpf = 1'b0, hne = 1'b0, hnf = 1'b0;

  always @(negedge clk1) begin
    exp_t e;
    if (rst_seen) begin
      hp = 8'h00; hpe = 1'b0; hpf = 1'b0;
      hn = 8'h00; hne = 1'b0; hnf = 1'b0;
    end
    rst_seen = rst;
    if (done_p === 1'b1) begin
      if (q_p.size() == 0) chk("unexpected_done_p", 32'd1, 32'd0);
      else begin
        e = q_p.pop_front();
        hp = e.data; hpe = e.perr; hpf = e.ferr;
        chk("done_window_p", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
        chk("busy_at_done_p", 32'(busy_p), 32'd0);
      end
    end
    if (done_n === 1'b1) begin
      done_n_cyc.push_back(cyc);
      if (q_n.size() == 0) chk("unexpected_done_n", 32'd1, 32'd0);
      else begin
        e = q_n.pop_front();
        hn = e.data; hne = e.perr; hnf = e.ferr;
        chk("done_window_n", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
        chk("busy_at_done_n", 32'(busy_n), 32'd0);
      end
    end
    chk("hold_p", {22'd0, rx_data_p, perr_p, ferr_p}, {22'd0, hp, hpe, hpf});
    chk("hold_n", {22'd0, rx_data_n, perr_n, ferr_n}, {22'd0, hn, hne, hnf});
  end

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_p = v;
    else rx_n = v;
  endtask

  task automatic idle(input int n);
    rx_p = 1'b1;
    rx_n = 1'b1;
    repeat (n) begin
      @(posedge clk1); #1;
    end
  endtask

  // which: 0 = parity instance, 1 = no-parity instance. abort_at >= 0 resets mid-bit of that frame bit.
  task automatic send_frame(input int which, input logic [7:0] data, input logic pbit,
                            input logic sbit, input int abort_at);
    logic b[$];
    exp_t e;
    int   nb;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(data[i]);
    if (which == 0) b.push_back(pbit);
    b.push_back(sbit);
    nb     = b.size();
    e.data = data;
    e.perr = (which == 0) ? (pbit ^ (^data)) : 1'b0;
    e.ferr = ~sbit;
    e.lo   = cyc + 16 * (nb - 1) + 6;
    e.hi   = cyc + 16 * nb + 2;
    if (abort_at < 0) begin
      if (which == 0) q_p.push_back(e);
      else q_n.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      drive(which, b[i]);
      for (int j = 0; j < 16; j++) begin
        if (i == abort_at && j == 8) begin
          rst = 1'b1;
          drive(which, 1'b1);
          @(posedge clk1); #1;
          rst = 1'b0;
          return;
        end
        @(posedge clk1); #1;
        if (i == 0 && j == 2) chk("busy_after_start", 32'(which == 0 ? busy_p : busy_n), 32'd1);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, kind, which, len;
    logic [7:0] d;
    logic       sb;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk1); #1;
    end
    chk("reset_rx_data", {rx_data_p, rx_data_n}, 16'h0000);
    chk("reset_flags", {perr_p, ferr_p, perr_n, ferr_n}, 4'h0);
    chk("reset_busy_done", {busy_p, done_p, busy_n, done_n}, 4'h0);
    rst = 1'b0;
    idle(20);

    // Clean frame, correct parity.
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
    idle(20);
    chk("t1_data", rx_data_p, 8'hA5);
    chk("t1_flags", {perr_p, ferr_p}, 2'b00);

    // Wrong parity bit.
    send_frame(0, 8'h37, 1'b0, 1'b1, -1);
    idle(20);
    chk("t2_data", rx_data_p, 8'h37);
    chk("t2_flags", {perr_p, ferr_p}, 2'b10);

    // Stop bit low.
    send_frame(0, 8'h00, 1'b0, 1'b0, -1);
    idle(40);
    chk("t3_data", rx_data_p, 8'h00);
    chk("t3_flags", {perr_p, ferr_p}, 2'b01);

    // Glitch: low for 4 cycles is a false start.
    t0 = cyc;
    rx_p = 1'b0;
    repeat (4) begin
      @(posedge clk1); #1;
    end
    rx_p = 1'b1;
    chk("t4_busy_during", busy_p, 1'b1);
    while (cyc < t0 + 14) begin
      @(posedge clk1); #1;
    end
    chk("t4_busy_after", busy_p, 1'b0);
    idle(20);
    chk("t4_outputs_held", {rx_data_p, perr_p, ferr_p}, {8'h00, 2'b01});

    // Reset during data bit 3 (frame bit 4).
    send_frame(0, 8'hC3, 1'b0, 1'b1, 4);
    chk("t5_reset_outputs", {rx_data_p, perr_p, ferr_p, busy_p, done_p}, 12'h000);
    idle(40);
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
    idle(20);
    chk("t5_data", rx_data_p, 8'h5A);
    chk("t5_flags", {perr_p, ferr_p}, 2'b00);

    // No parity, back-to-back frames.
    done_n_cyc.delete();
    send_frame(1, 8'h01, 1'b0, 1'b1, -1);
    chk("t6_first_data", rx_data_n, 8'h01);
    send_frame(1, 8'hFF, 1'b0, 1'b1, -1);
    idle(30);
    chk("t6_second_data", rx_data_n, 8'hFF);
    chk("t6_flags", {perr_n, ferr_n}, 2'b00);
    chk("t6_done_count", done_n_cyc.size(), 32'd2);
    if (done_n_cyc.size() == 2)
      chk("t6_done_spacing", done_n_cyc[1] - done_n_cyc[0], 32'd160);

    // Random traffic on both instances.
    for (int k = 0; k < 24; k++) begin
      which = $urandom_range(0, 1);
      kind  = $urandom_range(0, 9);
      if (kind == 0) begin
        len = $urandom_range(1, 5);
        drive(which, 1'b0);
        repeat (len) begin
          @(posedge clk1); #1;
        end
        idle(20 + $urandom_range(0, 10));
        chk("rand_false_start_busy", 32'(which == 0 ? busy_p : busy_n), 32'd0);
      end else begin
        d  = 8'($urandom);
        sb = (kind == 2) ? 1'b0 : 1'b1;
        send_frame(which, d, (^d) ^ (kind == 1), sb, -1);
        if (sb == 1'b0) idle(40);
        else idle($urandom_range(0, 24));
      end
    end

    idle(60);
    chk("pending_frames_p", q_p.size(), 32'd0);
    chk("pending_frames_n", q_n.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path. Deserialises an asynchronous serial line into bytes using a 16x oversampling tick.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, an optional even-parity bit (value = XOR of the data bits), and 1 stop bit (1).
- Sits at the far end of the line from the team's UART transmitter and hands each received byte to the host logic with a one-cycle done strobe and error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_EN, 1, 1 = a parity bit is expected after the data bits; 0 = no parity bit.
- OVERSAMPLE, 16, number of baud_rtick pulses per bit period (even, 8..16).

Ports:
- clk1  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_rtick  input  1  single-cycle enable pulse in the clk1 domain, at OVERSAMPLE x baud rate.
- rx  input  1  asynchronous serial line input; idles high.
- rx_data  output  DATA_BITS  last received data word.
- donerx  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit sampled as 0 on the last frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, clk1, rst=1):
  - State = IDLE; tick counter, bit index and shift register = 0.
  - rx_data = 0, donerx = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops = 1.
- rx passes through a 2-flop synchroniser; rx_s is the synchronised value, 2 clk1 cycles of latency. All sampling uses rx_s.
- Tick counter: width $clog2(OVERSAMPLE). It advances only on cycles where baud_rtick=1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_s=0 on any clk1 cycle (no tick required) -> START; counter = 0.
  - Otherwise stay in IDLE.
- START: on each tick the counter increments. On the tick where counter == OVERSAMPLE/2-1 (mid-bit):
  - rx_s=0 -> DATA; counter = 0; bit index = 0.
  - rx_s=1 -> false start: return to IDLE. No donerx, flags unchanged.
- DATA: on the tick where counter == OVERSAMPLE-1:
  - Sample rx_s into shift register position [bit index] (LSB first); counter = 0; bit index increments.
  - After bit index DATA_BITS-1: go to PARITY if PARITY_EN=1, otherwise STOP.
  - On all other ticks the counter increments.
- PARITY: sample at counter == OVERSAMPLE-1 into the parity register; counter = 0 -> STOP.
- STOP: sample at counter == OVERSAMPLE-1, then return to IDLE immediately at mid-stop bit, which allows resync on a back-to-back start edge.
- Completion, on the clk1 cycle after the stop sample:
  - rx_data <= shift register.
  - parity_err <= PARITY_EN & (parity_bit != ^data); forced to 0 when PARITY_EN=0.
  - frame_err <= ~stop_sample.
  - donerx = 1 for exactly one clk1 cycle.
- donerx pulses even when an error flag is set; data is still delivered.
- rx_data, parity_err and frame_err hold until the next completed frame. They are not cleared by a false start.
- No read handshake. The consumer must capture the output on donerx. A new frame overwrites the outputs without warning.
- Mid-frame rst returns to IDLE with all reset values on the next edge. A partial frame is discarded and produces no donerx.
- If baud_rtick is held high continuously, one bit period = OVERSAMPLE clk1 cycles. Behaviour is otherwise identical.
- Edge detection resolution is 1 clk1 cycle. Mid-bit sample error is at most 1 tick plus 2 cycles of synchroniser delay.

Test Plan (baud_rtick=1 every cycle, OVERSAMPLE=16, so 16 clk1 per bit):
1. Frame 0xA5, parity 0, stop 1 -> one donerx pulse; rx_data=0xA5; parity_err=0; frame_err=0. busy goes high within 3 cycles of the start edge and low at mid-stop.
2. Frame 0x37 sent with parity bit 0 (correct value is 1) -> donerx pulse; rx_data=0x37; parity_err=1; frame_err=0.
3. Frame 0x00, parity 0, stop bit driven 0 -> donerx pulse; rx_data=0x00; frame_err=1; parity_err=0.
4. rx low for 4 cycles, then high -> no donerx; busy returns to 0 by about cycle 10; rx_data unchanged from the prior frame.
5. rst pulsed for 1 cycle during data bit 3 of a frame -> all outputs take reset values; no donerx for the aborted frame. A following clean 0x5A frame is received correctly.
6. PARITY_EN=0, frames 0x01 then 0xFF back-to-back with zero idle bits -> two donerx pulses 10 bit periods apart; rx_data 0x01 then 0xFF; both error flags 0.
